// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and two-stage request pipeline sharing the data memory between
// the core load/store port and the debug/loader port; responses are routed back to their issuer.
module dmem_arbiter #(
  parameter int MEM_ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [31:0]           core_addr,
  input  logic [31:0]           core_wdata,
  input  logic [3:0]            core_be,
  output logic                  core_gnt,
  output logic                  core_rvalid,
  output logic [31:0]           core_rdata,
  output logic                  core_err,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [31:0]           dbg_addr,
  input  logic [31:0]           dbg_wdata,
  input  logic [3:0]            dbg_be,
  output logic                  dbg_gnt,
  output logic                  dbg_rvalid,
  output logic [31:0]           dbg_rdata,
  output logic                  dbg_err,
  input  logic                  dbg_lock,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_be,
  input  logic [31:0]           mem_rdata
);

  localparam logic OWN_CORE = 1'b0;
  localparam logic OWN_DBG  = 1'b1;

  // Word index of a byte address; bits above the memory size must be zero to be in range.
  function automatic logic word_in_range(input logic [31:0] word);
    return (word[31:MEM_ADDR_W] == '0);
  endfunction

  logic        last_owner;
  logic        any_gnt;
  logic        sel_we;
  logic [31:0] sel_word;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_be;
  logic        sel_in_range;

  logic        s1_valid, s1_owner, s1_read, s1_err;
  logic        s2_valid, s2_owner, s2_read, s2_err;
  logic [31:0] resp_data;

  // Grant selection: lock favours debug, otherwise alternate on conflict.
  always_comb begin
    core_gnt = 1'b0;
    dbg_gnt  = 1'b0;
    if (dbg_lock) begin
      dbg_gnt = dbg_req;
    end else if (core_req && dbg_req) begin
      if (last_owner == OWN_DBG) begin
        core_gnt = 1'b1;
      end else begin
        dbg_gnt = 1'b1;
      end
    end else begin
      core_gnt = core_req;
      dbg_gnt  = dbg_req;
    end
  end

  // Mux the granted requester's fields; the word shift keeps every address bit in use.
  always_comb begin
    any_gnt = core_gnt | dbg_gnt;
    if (dbg_gnt) begin
      sel_we    = dbg_we;
      sel_word  = dbg_addr >> 2;
      sel_wdata = dbg_wdata;
      sel_be    = dbg_be;
    end else begin
      sel_we    = core_we;
      sel_word  = core_addr >> 2;
      sel_wdata = core_wdata;
      sel_be    = core_be;
    end
    sel_in_range = word_in_range(sel_word);
  end

  // Round-robin pointer remembers who was granted most recently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner <= OWN_DBG;
    end else if (any_gnt) begin
      last_owner <= dbg_gnt;
    end
  end

  // Stage 1: memory command registers; fields only change for in-range grants.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'h0000_0000;
      mem_be    <= 4'h0;
    end else begin
      mem_en <= any_gnt & sel_in_range;
      if (any_gnt && sel_in_range) begin
        mem_we    <= sel_we;
        mem_addr  <= sel_word[MEM_ADDR_W-1:0];
        mem_wdata <= sel_wdata;
        mem_be    <= sel_be;
      end
    end
  end

  // Response tag shift register {valid, owner, is_read, err}.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_owner <= OWN_CORE;
      s1_read  <= 1'b0;
      s1_err   <= 1'b0;
      s2_valid <= 1'b0;
      s2_owner <= OWN_CORE;
      s2_read  <= 1'b0;
      s2_err   <= 1'b0;
    end else begin
      s1_valid <= any_gnt;
      s1_owner <= dbg_gnt;
      s1_read  <= any_gnt & ~sel_we;
      s1_err   <= any_gnt & ~sel_in_range;
      s2_valid <= s1_valid;
      s2_owner <= s1_owner;
      s2_read  <= s1_read;
      s2_err   <= s1_err;
    end
  end

  // Route the stage-2 response to its owner; only good reads carry memory data.
  always_comb begin
    if (s2_valid && s2_read && !s2_err) begin
      resp_data = mem_rdata;
    end else begin
      resp_data = 32'h0000_0000;
    end
    core_rvalid = s2_valid & (s2_owner == OWN_CORE);
    dbg_rvalid  = s2_valid & (s2_owner == OWN_DBG);
    core_err    = core_rvalid & s2_err;
    dbg_err     = dbg_rvalid & s2_err;
    if (core_rvalid) begin
      core_rdata = resp_data;
    end else begin
      core_rdata = 32'h0000_0000;
    end
    if (dbg_rvalid) begin
      dbg_rdata = resp_data;
    end else begin
      dbg_rdata = 32'h0000_0000;
    end
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and request pipeline in front of the single-port data memory. It shares the memory between the core load/store port (requester 0) and a debug/loader port (requester 1), which is used to preload or inspect data memory at run time. Arbitration is round-robin, with an optional debug lock. Requests are accepted with a req/gnt handshake. Memory signals are registered, and each response is routed back to the requester that issued it.

## Interface
- MEM_ADDR_W, 10: word-address width of data memory; capacity is 4·2^MEM_ADDR_W bytes.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- core_req  in  1  core request valid; held until core_gnt.
- core_we  in  1  1 = write, 0 = read.
- core_addr  in  32  byte address; bits [1:0] ignored.
- core_wdata  in  32  write data.
- core_be  in  4  byte enables for writes.
- core_gnt  out  1  combinational accept of the core request this cycle.
- core_rvalid  out  1  response valid, 1-cycle pulse.
- core_rdata  out  32  read data; 0 for writes and errors.
- core_err  out  1  qualifies core_rvalid: address out of range.
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_be, dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err: identical to core_*, for the debug port.
- dbg_lock  in  1  while high, only the debug port can be granted.
- mem_en  out  1  registered memory strobe.
- mem_we  out  1  registered write enable.
- mem_addr  out  MEM_ADDR_W  registered word address, addr[MEM_ADDR_W+1:2].
- mem_wdata  out  32  registered write data.
- mem_be  out  4  registered byte enables.
- mem_rdata  in  32  memory read data, valid the cycle after mem_en with mem_we=0.

## Operation
- **Arbitration** (combinational, same cycle as req):
  - One request: that requester is granted, unless it is core and dbg_lock=1.
  - Both requests, dbg_lock=0: grant the requester not granted last (pointer `last`).
  - Both requests, dbg_lock=1: grant dbg.
  - At most one gnt per cycle.
  - `last` updates on every grant. Reset value is dbg, so core wins the first conflict.
- **Range check**: a granted request is in range if addr[31:MEM_ADDR_W+2] == 0.
  - In range: stage 1 registers mem_en=1 with mem_we, mem_addr, mem_wdata, mem_be.
  - Out of range: mem_en=0, and the stage-1 error flag is set.
- **Response pipeline**: a 2-stage tag shift register carrying {valid, owner, is_read, err}.
  - Stage 1 is loaded on a grant.
  - Stage 2 is loaded from stage 1.
  - Stage 2 drives the owner's rvalid.
- **rdata**:
  - In-range read: mem_rdata, passed through combinationally from the stage-2 cycle.
  - Write or error: 0.
- **err**: equals the stage-2 error flag, only with the owner's rvalid.
- **Throughput**: the pipeline never stalls, so one grant per cycle is sustained. Back-to-back grants may alternate owners.
- **Write ack**: writes also produce rvalid. This lets the core LSU treat stores and loads uniformly.
- **Request rules**:
  - A requester must not change its request fields while req=1 and gnt=0.
  - A requester may issue a new request the cycle after gnt, without waiting for rvalid.

## Timing
- **Reset (rst_n=0, asynchronous)**: every output that depends on state is 0 (mem_en, mem_we, mem_addr, mem_wdata, mem_be, *_rvalid, *_err); *_rdata is 0 because no stage-2 tag is valid. gnt outputs stay combinational from req and dbg_lock, as in normal operation. `last`=dbg and both pipeline stages are invalid.
- **Latency**:
  - Grant in cycle N.
  - mem_en/addr valid in cycle N+1.
  - rvalid/rdata in cycle N+2, for reads, writes and errors alike.
- **Write commit**: the memory write commits at the rising edge ending cycle N+1.
- **Ordering**:
  - Responses return in grant order.
  - core_rvalid and dbg_rvalid are never high in the same cycle.
- **Reset mid-operation**: in-flight tags are discarded. No rvalid is produced for requests granted before reset. A write already registered in stage 1 at the moment of reset is cancelled (mem_en clears asynchronously).
- **Lock changes**: dbg_lock rising while core_req is pending blocks core starting that same cycle. Already-granted core transactions still complete.
- **Address boundaries**: the highest legal word, 4·2^MEM_ADDR_W − 4, is in range. One word above it sets err.

## Test plan
- **Reset**: assert rst_n=0 mid-read (grant in cycle N, reset in N+1) -> all state-driven outputs 0 immediately; no rvalid in N+2; after release, core_req alone -> core_gnt same cycle.
- **Read latency**: dbg write 0xDEADBEEF, be=4'hF, to 0x10; then core read 0x10 -> mem_addr=4 one cycle after the core grant; core_rvalid with rdata=0xDEADBEEF two cycles after grant; dbg_rvalid low.
- **Round-robin**: core_req and dbg_req held high for 4 cycles, dbg_lock=0 -> gnt order core, dbg, core, dbg; rvalid pattern the same, shifted by 2 cycles.
- **Lock**: dbg_lock=1 with both requesting for 3 cycles -> dbg_gnt each cycle, core_gnt=0; drop lock -> core granted next cycle.
- **Byte enables**: write 0x11223344 be=4'h2 over 0xFFFFFFFF -> readback 0xFFFF33FF.
- **Range error**, MEM_ADDR_W=10: read 0x00000FFC -> err=0; read 0x00001000 -> mem_en stays 0, rvalid with err=1 and rdata=0 two cycles after grant.
